score_bcd: RTL and testbench

- Sequential binary-to-BCD converter sitting directly upstream of the score text renderer.
- Takes the binary game score from the game logic and produces registered, tear-free decimal digits (thousands..units) for the renderer to turn into glyphs.
- Replaces chained combinational dividers with a multi-cycle shift-add-3 (double dabble) engine.

---
 rtl/score_bcd_pkg.sv | 23 ++
 rtl/score_bcd_if.sv | 15 +
 rtl/score_bcd_add3.sv | 7 +
 rtl/score_bcd.sv | 148 ++++++++++++++
 tb/tb_score_bcd.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/score_bcd_pkg.sv
// Shared package for score_bcd: nibble sizing, FSM encoding and constant helpers.
package score_pkg;
   localparam int DIGITS_DEF = 4;
   localparam int NIB_W      = 4;

   typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_e;

   // Smallest r with 2**r >= x.
   function automatic int logb2(input int x);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < x) r = i + 1;
      return r;
   endfunction

   function automatic int max_disp(input int d);
      int m;
      m = 1;
      for (int i = 0; i < d; i++) m = m * 10;
      return m - 1;
   endfunction
endpackage

// File: rtl/score_bcd_if.sv
// Score/digits bundle between game logic (master) and the BCD converter (slave).
interface score_bcd_if #(
   parameter int SCORE_BITS = 10,
   parameter int DIGITS     = 4
);
   logic [SCORE_BITS-1:0] score;
   logic [4*DIGITS-1:0]   digits;
   logic                  valid;
   logic                  busy;
   logic                  overflow;
   logic [DIGITS-1:0]     blank;

   modport master (output score, input digits, valid, busy, overflow, blank);
   modport slave  (input score, output digits, valid, busy, overflow, blank);
endinterface

// File: rtl/score_bcd_add3.sv
// Double-dabble nibble correction: values of 5 or more get 3 added before the shift.
module bcd_add3 (
   input  logic [3:0] in,
   output logic [3:0] out
);
   assign out = (in >= 4'd5) ? in + 4'd3 : in;
endmodule

// File: rtl/score_bcd.sv
// Multi-cycle binary-to-BCD score converter with tear-free registered digits.
// Optional leading-zero blanking is built only when SCORE_BCD_BLANK_EN is defined.
module score_bcd
   import score_pkg::*;
#(
   parameter int H      = 32,
   parameter int V      = 32,
   parameter int DIGITS = DIGITS_DEF
) (
   input logic        clk,
   input logic        rst_n,
   score_bcd_if.slave bus
);
   localparam int SCORE_BITS = logb2(H * V);
   localparam int ACC_W      = NIB_W * (DIGITS + 1);
   localparam int CNT_W      = logb2(SCORE_BITS + 1);
   localparam logic [31:0] MAX_DISP = 32'(max_disp(DIGITS));

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SCORE_BITS-1:0]   bin_q, bin_d;
   logic [SCORE_BITS-1:0]   last_q, last_d;
   logic [ACC_W-1:0]        bcd_q, bcd_d;
   logic                    force_q, force_d;
   logic                    ovf_q, ovf_d;
   logic [NIB_W*DIGITS-1:0] digits_q, digits_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic                    overflow_q, overflow_d;
   logic [ACC_W-1:0]        bcd_adj;
   logic [ACC_W+SCORE_BITS-1:0] shifted;

   for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
      bcd_add3 u_add3 (.in(bcd_q[g*NIB_W +: NIB_W]), .out(bcd_adj[g*NIB_W +: NIB_W]));
   end

   assign shifted = {bcd_adj, bin_q} << 1;

`ifdef SCORE_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d, blank_pub;
   logic              zero_run;

   // Walk down from the top digit; bit 0 is never blanked so zero still shows.
   always_comb begin
      blank_pub = '0;
      zero_run  = ~ovf_q;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run & (bcd_q[NIB_W*i +: NIB_W] == '0);
         blank_pub[i] = zero_run;
      end
   end

   assign bus.blank = blank_q;
`else
   assign bus.blank = '0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      last_d     = last_q;
      bcd_d      = bcd_q;
      force_d    = force_q;
      ovf_d      = ovf_q;
      digits_d   = digits_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      overflow_d = overflow_q;
`ifdef SCORE_BCD_BLANK_EN
      blank_d    = blank_q;
`endif
      case (state_q)
         IDLE: begin
            if (force_q || (bus.score != last_q)) begin
               bin_d   = bus.score;
               last_d  = bus.score;
               bcd_d   = '0;
               ovf_d   = (32'(bus.score) > MAX_DISP);
               cnt_d   = CNT_W'(SCORE_BITS);
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // The cycle that finds the counter at zero is a settle cycle before publishing.
            if (cnt_q != '0) begin
               bcd_d = shifted[ACC_W+SCORE_BITS-1:SCORE_BITS];
               bin_d = shifted[SCORE_BITS-1:0];
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = PUBLISH;
            end
         end
         PUBLISH: begin
            digits_d   = ovf_q ? {DIGITS{4'h9}} : bcd_q[NIB_W*DIGITS-1:0];
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            force_d    = 1'b0;
`ifdef SCORE_BCD_BLANK_EN
            blank_d    = blank_pub;
`endif
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         last_q     <= '0;
         bcd_q      <= '0;
         force_q    <= 1'b1;
         ovf_q      <= 1'b0;
         digits_q   <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
`ifdef SCORE_BCD_BLANK_EN
         blank_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         last_q     <= last_d;
         bcd_q      <= bcd_d;
         force_q    <= force_d;
         ovf_q      <= ovf_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
`ifdef SCORE_BCD_BLANK_EN
         blank_q    <= blank_d;
`endif
      end
   end

   assign bus.digits   = digits_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_score_bcd.sv
// Bench for score_bcd: a 32x32 instance (10-bit score) and a 128x128 instance (14-bit score).
module tb_score_bcd;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   score_bcd_if #(.SCORE_BITS(10), .DIGITS(4)) if_a ();
   score_bcd_if #(.SCORE_BITS(14), .DIGITS(4)) if_b ();

   score_bcd #(.H(32),  .V(32))  dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   score_bcd #(.H(128), .V(128)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

`ifdef SCORE_BCD_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   typedef struct {
      bit          sel;
      int          score;
      logic [15:0] dig;
      bit          ovf;
      logic [3:0]  blk;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] rd_dig(input bit s);
      return s ? if_b.digits : if_a.digits;
   endfunction
   function automatic logic rd_busy(input bit s);
      return s ? if_b.busy : if_a.busy;
   endfunction

   task automatic drive(input bit s, input int v);
      if (s) if_b.score = 14'(v);
      else   if_a.score = 10'(v);
   endtask

   // Reference: plain decimal arithmetic, saturating to 9999.
   function automatic logic [15:0] mdl_dig(input int v);
      if (v > 9999) return 16'h9999;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   function automatic logic [3:0] mdl_blank(input int v);
      logic [3:0] b;
      b = '0;
      if (v <= 9999) begin
         if (v < 1000) b[3] = 1'b1;
         if (v < 100)  b[2] = 1'b1;
         if (v < 10)   b[1] = 1'b1;
      end
      return b;
   endfunction

   // Apply a new score to an idle DUT; digits must hold until exactly the publish edge.
   task automatic conv(input bit s, input int v, input logic [15:0] exp_dig, input bit exp_ovf,
                       input logic [3:0] exp_blk, input string name);
      int          lat;
      int          bad;
      logic [15:0] prev;
      lat  = s ? 16 : 12;
      prev = rd_dig(s);
      bad  = 0;
      drive(s, v);
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (rd_dig(s) !== prev) bad++;
         if (rd_busy(s) !== 1'b1) bad++;
      end
      chk({name, " hold"}, bad, 0);
      tick();
      chk({name, " digits"}, rd_dig(s), exp_dig);
      chk({name, " busy"}, rd_busy(s), 0);
      chk({name, " valid"}, s ? if_b.valid : if_a.valid, 1);
      chk({name, " ovf"}, s ? if_b.overflow : if_a.overflow, exp_ovf);
      chk({name, " blank"}, s ? if_b.blank : if_a.blank, BLANK_ON ? exp_blk : 4'b0000);
   endtask

   initial begin
      int          bad;
      int          v;
      int          prev_v;
      logic [15:0] d;
      logic [15:0] prev;

      tbl.push_back('{0, 1023,  16'h1023, 0, 4'b0000});
      tbl.push_back('{0, 0,     16'h0000, 0, 4'b1110});
      tbl.push_back('{0, 9,     16'h0009, 0, 4'b1110});
      tbl.push_back('{0, 10,    16'h0010, 0, 4'b1100});
      tbl.push_back('{0, 99,    16'h0099, 0, 4'b1100});
      tbl.push_back('{0, 100,   16'h0100, 0, 4'b1000});
      tbl.push_back('{0, 999,   16'h0999, 0, 4'b1000});
      tbl.push_back('{0, 1000,  16'h1000, 0, 4'b0000});
      tbl.push_back('{0, 512,   16'h0512, 0, 4'b1000});
      tbl.push_back('{0, 42,    16'h0042, 0, 4'b1100});
      tbl.push_back('{1, 12345, 16'h9999, 1, 4'b0000});
      tbl.push_back('{1, 42,    16'h0042, 0, 4'b1100});
      tbl.push_back('{1, 9999,  16'h9999, 0, 4'b0000});
      tbl.push_back('{1, 10000, 16'h9999, 1, 4'b0000});
      tbl.push_back('{1, 16383, 16'h9999, 1, 4'b0000});
      tbl.push_back('{1, 0,     16'h0000, 0, 4'b1110});

      rst_n = 1'b0;
      if_a.score = '0;
      if_b.score = '0;
      tick();
      tick();
      chk("rst digits", if_a.digits, 0);
      chk("rst valid", if_a.valid, 0);
      chk("rst busy", if_a.busy, 0);
      chk("rst ovf", if_a.overflow, 0);
      chk("rst blank", if_a.blank, 0);
      chk("rst b valid", if_b.valid, 0);

      // Forced first conversion of score 0 after reset release.
      rst_n = 1'b1;
      bad = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (if_a.valid !== 1'b0 || if_a.digits !== 16'h0000 || if_a.busy !== 1'b1) bad++;
      end
      chk("boot hold", bad, 0);
      tick();
      chk("boot valid", if_a.valid, 1);
      chk("boot digits", if_a.digits, 0);
      chk("boot busy", if_a.busy, 0);
      chk("boot blank", if_a.blank, BLANK_ON ? 4'b1110 : 4'b0000);
      repeat (6) tick();
      chk("boot b valid", if_b.valid, 1);

      foreach (tbl[i])
         if (!tbl[i].sel) conv(0, tbl[i].score, tbl[i].dig, tbl[i].ovf, tbl[i].blk, "tbl_a");

      prev_v = 42;
      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(0, 1023));
         if (v == prev_v) v = (v + 1) % 1024;
         conv(0, v, mdl_dig(v), 0, mdl_blank(v), "rand_a");
         prev_v = v;
      end

      // Score changes mid-conversion: 5 publishes first, then 7 one full conversion later.
      if (prev_v == 5) conv(0, 6, 16'h0006, 0, 4'b1110, "pre_mid");
      prev = if_a.digits;
      drive(0, 5);
      bad = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (k == 3) drive(0, 7);
         d = if_a.digits;
         if (d !== prev && d !== 16'h0005 && d !== 16'h0007) bad++;
         if (k == 13) begin
            chk("mid first", d, 16'h0005);
            chk("mid idle busy", if_a.busy, 0);
         end
         if (k == 25) chk("mid still5", d, 16'h0005);
      end
      tick();
      chk("mid second", if_a.digits, 16'h0007);
      chk("mid no tear", bad, 0);

      // Reset pulse in the middle of a conversion.
      drive(0, 300);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      chk("abort digits", if_a.digits, 0);
      chk("abort valid", if_a.valid, 0);
      chk("abort busy", if_a.busy, 0);
      chk("abort ovf", if_a.overflow, 0);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (if_a.valid !== 1'b0) bad++;
      end
      chk("abort hold", bad, 0);
      tick();
      chk("abort digits2", if_a.digits, 16'h0300);
      chk("abort valid2", if_a.valid, 1);
      repeat (6) tick();

      foreach (tbl[i])
         if (tbl[i].sel) conv(1, tbl[i].score, tbl[i].dig, tbl[i].ovf, tbl[i].blk, "tbl_b");

      prev_v = 0;
      for (int i = 0; i < 10; i++) begin
         v = int'($urandom_range(0, 16383));
         if (v == prev_v) v = (v + 1) % 16384;
         conv(1, v, mdl_dig(v), v > 9999, mdl_blank(v), "rand_b");
         prev_v = v;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
